// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares the single cache-line memory port between instruction-
//            cache refills and data-cache refills/writebacks. One memory
//            transaction is outstanding at a time, and each completion is
//            routed back to the requester that owns it.
// Ports    :
//   clk_i / rst_i          clock, asynchronous active-high reset
//   ic_rd_req_i, ic_addr_i icache line read request (level) and address
//   ic_rsp_valid_o/data_o  icache response pulse and returned line
//   dc_rd_req_i/wr_req_i   dcache read / write requests (levels)
//   dc_addr_i, dc_wr_data_i, dc_size_i   dcache request payload
//   dc_rsp_valid_o/data_o  dcache read response pulse and returned line
//   dc_wr_done_o           dcache write committed pulse
//   mem_rd_req_o/wr_req_o  memory request strobes
//   mem_req_is_instr_o     request is on behalf of the icache
//   mem_addr_o, mem_wr_data_o, mem_size_o   memory request payload
//   mem_data_valid_i, mem_data_is_instr_i, mem_data_i   memory read return
//   mem_wr_done_i          memory write completion
//   busy_o                 a transaction or response slot is in progress
//   err_o                  sticky: read data returned with the wrong tag
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    LINE_BITS      = 128,
  parameter int                    SIZE_WIDTH     = 2,
  // Access-size code meaning "whole cache line"; icache refills always use it.
  parameter logic [SIZE_WIDTH-1:0] LINE_SIZE_CODE = '1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // icache side
  input  logic                  ic_rd_req_i,
  input  logic [ADDR_WIDTH-1:0] ic_addr_i,
  output logic                  ic_rsp_valid_o,
  output logic [LINE_BITS-1:0]  ic_rsp_data_o,
  // dcache side
  input  logic                  dc_rd_req_i,
  input  logic                  dc_wr_req_i,
  input  logic [ADDR_WIDTH-1:0] dc_addr_i,
  input  logic [LINE_BITS-1:0]  dc_wr_data_i,
  input  logic [SIZE_WIDTH-1:0] dc_size_i,
  output logic                  dc_rsp_valid_o,
  output logic [LINE_BITS-1:0]  dc_rsp_data_o,
  output logic                  dc_wr_done_o,
  // memory side
  output logic                  mem_rd_req_o,
  output logic                  mem_wr_req_o,
  output logic                  mem_req_is_instr_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [LINE_BITS-1:0]  mem_wr_data_o,
  output logic [SIZE_WIDTH-1:0] mem_size_o,
  input  logic                  mem_data_valid_i,
  input  logic                  mem_data_is_instr_i,
  input  logic [LINE_BITS-1:0]  mem_data_i,
  input  logic                  mem_wr_done_i,
  // status
  output logic                  busy_o,
  output logic                  err_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_I = 3'd1,
    ST_RD_D = 3'd2,
    ST_WR_D = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic                   last_grant_dc_q, last_grant_dc_d;
  logic                   err_q, err_d;

  // Request payload captured on the grant edge and held for the transaction.
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [LINE_BITS-1:0]   wr_data_q, wr_data_d;
  logic [SIZE_WIDTH-1:0]  size_q, size_d;
  logic                   is_instr_q, is_instr_d;

  // Response pulses are registered on the completion edge so they line up
  // exactly with the single RESP cycle.
  logic                   ic_rsp_valid_q, ic_rsp_valid_d;
  logic                   dc_rsp_valid_q, dc_rsp_valid_d;
  logic                   dc_wr_done_q, dc_wr_done_d;
  logic [LINE_BITS-1:0]   ic_rsp_data_q, ic_rsp_data_d;
  logic [LINE_BITS-1:0]   dc_rsp_data_q, dc_rsp_data_d;

  // --------------------------------------------------------------------------
  // Arbitration. Writes outrank reads within the dcache. Between the two
  // caches the side that did not win last time gets priority, so a
  // continuously requesting cache can never starve the other one.
  // --------------------------------------------------------------------------
  logic w_dc_req;
  logic w_grant_ic;
  logic w_grant_dc;

  assign w_dc_req   = dc_wr_req_i | dc_rd_req_i;
  assign w_grant_ic = ic_rd_req_i & (~w_dc_req | last_grant_dc_q);
  assign w_grant_dc = w_dc_req & ~w_grant_ic;

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    last_grant_dc_d = last_grant_dc_q;
    err_d           = err_q;
    addr_d          = addr_q;
    wr_data_d       = wr_data_q;
    size_d          = size_q;
    is_instr_d      = is_instr_q;
    ic_rsp_valid_d  = 1'b0;
    dc_rsp_valid_d  = 1'b0;
    dc_wr_done_d    = 1'b0;
    ic_rsp_data_d   = ic_rsp_data_q;
    dc_rsp_data_d   = dc_rsp_data_q;

    unique case (state_q)
      ST_IDLE: begin
        // Memory completions seen here are stale (e.g. after a reset) and
        // are deliberately not looked at.
        if (w_grant_ic) begin
          state_d         = ST_RD_I;
          last_grant_dc_d = 1'b0;
          addr_d          = ic_addr_i;
          wr_data_d       = '0;
          size_d          = LINE_SIZE_CODE;
          is_instr_d      = 1'b1;
        end else if (w_grant_dc) begin
          last_grant_dc_d = 1'b1;
          addr_d          = dc_addr_i;
          size_d          = dc_size_i;
          is_instr_d      = 1'b0;
          if (dc_wr_req_i) begin
            state_d   = ST_WR_D;
            wr_data_d = dc_wr_data_i;
          end else begin
            state_d   = ST_RD_D;
            wr_data_d = '0;
          end
        end
      end

      ST_RD_I: begin
        if (mem_data_valid_i) begin
          if (mem_data_is_instr_i) begin
            state_d        = ST_RESP;
            ic_rsp_data_d  = mem_data_i;
            ic_rsp_valid_d = 1'b1;
          end else begin
            // Data belongs to nobody we are waiting for: keep waiting.
            err_d = 1'b1;
          end
        end
      end

      ST_RD_D: begin
        if (mem_data_valid_i) begin
          if (!mem_data_is_instr_i) begin
            state_d        = ST_RESP;
            dc_rsp_data_d  = mem_data_i;
            dc_rsp_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_WR_D: begin
        if (mem_wr_done_i) begin
          state_d      = ST_RESP;
          dc_wr_done_d = 1'b1;
        end
      end

      // One dead cycle gives the requester time to drop its level before
      // arbitration looks at it again.
      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      last_grant_dc_q <= 1'b1;
      err_q           <= 1'b0;
      addr_q          <= '0;
      wr_data_q       <= '0;
      size_q          <= '0;
      is_instr_q      <= 1'b0;
      ic_rsp_valid_q  <= 1'b0;
      dc_rsp_valid_q  <= 1'b0;
      dc_wr_done_q    <= 1'b0;
      ic_rsp_data_q   <= '0;
      dc_rsp_data_q   <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_dc_q <= last_grant_dc_d;
      err_q           <= err_d;
      addr_q          <= addr_d;
      wr_data_q       <= wr_data_d;
      size_q          <= size_d;
      is_instr_q      <= is_instr_d;
      ic_rsp_valid_q  <= ic_rsp_valid_d;
      dc_rsp_valid_q  <= dc_rsp_valid_d;
      dc_wr_done_q    <= dc_wr_done_d;
      ic_rsp_data_q   <= ic_rsp_data_d;
      dc_rsp_data_q   <= dc_rsp_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Strobes come straight from the state register, so they rise the
  // cycle after the grant edge and fall the cycle after completion.
  // --------------------------------------------------------------------------
  assign mem_rd_req_o       = (state_q == ST_RD_I) || (state_q == ST_RD_D);
  assign mem_wr_req_o       = (state_q == ST_WR_D);
  assign mem_req_is_instr_o = is_instr_q;
  assign mem_addr_o         = addr_q;
  assign mem_wr_data_o      = wr_data_q;
  assign mem_size_o         = size_q;

  assign ic_rsp_valid_o     = ic_rsp_valid_q;
  assign ic_rsp_data_o      = ic_rsp_data_q;
  assign dc_rsp_valid_o     = dc_rsp_valid_q;
  assign dc_rsp_data_o      = dc_rsp_data_q;
  assign dc_wr_done_o       = dc_wr_done_q;

  assign busy_o             = (state_q != ST_IDLE);
  assign err_o              = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Randomized bench for mem_arbiter. Two requester processes and a
//            memory responder drive traffic; a transaction-level reference
//            model predicts grants and responses into queues that a monitor
//            drains and compares against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int LB = 128;
  localparam int SW = 2;
  localparam logic [SW-1:0] FULL_LINE = 2'b11;

  localparam int O_NONE = 0;
  localparam int O_IC   = 1;
  localparam int O_DR   = 2;
  localparam int O_DW   = 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          ic_rd_req_i = 1'b0;
  logic [AW-1:0] ic_addr_i = '0;
  logic          ic_rsp_valid_o;
  logic [LB-1:0] ic_rsp_data_o;
  logic          dc_rd_req_i = 1'b0;
  logic          dc_wr_req_i = 1'b0;
  logic [AW-1:0] dc_addr_i = '0;
  logic [LB-1:0] dc_wr_data_i = '0;
  logic [SW-1:0] dc_size_i = '0;
  logic          dc_rsp_valid_o;
  logic [LB-1:0] dc_rsp_data_o;
  logic          dc_wr_done_o;
  logic          mem_rd_req_o;
  logic          mem_wr_req_o;
  logic          mem_req_is_instr_o;
  logic [AW-1:0] mem_addr_o;
  logic [LB-1:0] mem_wr_data_o;
  logic [SW-1:0] mem_size_o;
  logic          mem_data_valid_i = 1'b0;
  logic          mem_data_is_instr_i = 1'b0;
  logic [LB-1:0] mem_data_i = '0;
  logic          mem_wr_done_i = 1'b0;
  logic          busy_o;
  logic          err_o;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(
    .ADDR_WIDTH(AW), .LINE_BITS(LB), .SIZE_WIDTH(SW), .LINE_SIZE_CODE(FULL_LINE)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ic_rd_req_i(ic_rd_req_i), .ic_addr_i(ic_addr_i),
    .ic_rsp_valid_o(ic_rsp_valid_o), .ic_rsp_data_o(ic_rsp_data_o),
    .dc_rd_req_i(dc_rd_req_i), .dc_wr_req_i(dc_wr_req_i), .dc_addr_i(dc_addr_i),
    .dc_wr_data_i(dc_wr_data_i), .dc_size_i(dc_size_i),
    .dc_rsp_valid_o(dc_rsp_valid_o), .dc_rsp_data_o(dc_rsp_data_o),
    .dc_wr_done_o(dc_wr_done_o),
    .mem_rd_req_o(mem_rd_req_o), .mem_wr_req_o(mem_wr_req_o),
    .mem_req_is_instr_o(mem_req_is_instr_o), .mem_addr_o(mem_addr_o),
    .mem_wr_data_o(mem_wr_data_o), .mem_size_o(mem_size_o),
    .mem_data_valid_i(mem_data_valid_i), .mem_data_is_instr_i(mem_data_is_instr_i),
    .mem_data_i(mem_data_i), .mem_wr_done_i(mem_wr_done_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  // --------------------------------------------------------------------------
  // Check bookkeeping
  // --------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ic_rsp_valid"}, ic_rsp_valid_o, 0);
    chk({tag, "_ic_rsp_data"},  ic_rsp_data_o, 0);
    chk({tag, "_dc_rsp_valid"}, dc_rsp_valid_o, 0);
    chk({tag, "_dc_rsp_data"},  dc_rsp_data_o, 0);
    chk({tag, "_dc_wr_done"},   dc_wr_done_o, 0);
    chk({tag, "_mem_rd_req"},   mem_rd_req_o, 0);
    chk({tag, "_mem_wr_req"},   mem_wr_req_o, 0);
    chk({tag, "_is_instr"},     mem_req_is_instr_o, 0);
    chk({tag, "_mem_addr"},     mem_addr_o, 0);
    chk({tag, "_mem_wr_data"},  mem_wr_data_o, 0);
    chk({tag, "_mem_size"},     mem_size_o, 0);
    chk({tag, "_busy"},         busy_o, 0);
    chk({tag, "_err"},          err_o, 0);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: who owns the port, whether the response slot is active,
  // which side won last, and the sticky error. Predictions go into queues.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic          wr;
    logic          instr;
    logic [AW-1:0] addr;
    logic [LB-1:0] wdata;
    logic [SW-1:0] size;
  } req_t;

  typedef struct packed {
    logic [1:0]    kind;
    logic [LB-1:0] data;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];

  int m_own     = O_NONE;
  bit m_resp    = 1'b0;
  bit m_last_dc = 1'b1;
  bit m_err     = 1'b0;

  function automatic int pick_winner(bit ic, bit dr, bit dw, bit last_dc);
    int dc_kind;
    dc_kind = dw ? O_DW : O_DR;
    if (ic && (dr || dw)) return last_dc ? O_IC : dc_kind;
    if (ic)               return O_IC;
    if (dr || dw)         return dc_kind;
    return O_NONE;
  endfunction

  function automatic req_t make_req(int who);
    req_t r;
    r.wr    = (who == O_DW);
    r.instr = (who == O_IC);
    r.addr  = (who == O_IC) ? ic_addr_i : dc_addr_i;
    r.wdata = (who == O_DW) ? dc_wr_data_i : '0;
    r.size  = (who == O_IC) ? FULL_LINE : dc_size_i;
    return r;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_own     <= O_NONE;
      m_resp    <= 1'b0;
      m_last_dc <= 1'b1;
      m_err     <= 1'b0;
      exp_req.delete();
      exp_rsp.delete();
    end else if (m_resp) begin
      m_resp <= 1'b0;
    end else if (m_own == O_NONE) begin
      if (pick_winner(ic_rd_req_i, dc_rd_req_i, dc_wr_req_i, m_last_dc) != O_NONE) begin
        m_own     <= pick_winner(ic_rd_req_i, dc_rd_req_i, dc_wr_req_i, m_last_dc);
        m_last_dc <= (pick_winner(ic_rd_req_i, dc_rd_req_i, dc_wr_req_i, m_last_dc) != O_IC);
        exp_req.push_back(make_req(pick_winner(ic_rd_req_i, dc_rd_req_i, dc_wr_req_i, m_last_dc)));
      end
    end else if (m_own == O_DW) begin
      if (mem_wr_done_i) begin
        exp_rsp.push_back({2'(O_DW), {LB{1'b0}}});
        m_own  <= O_NONE;
        m_resp <= 1'b1;
      end
    end else if (mem_data_valid_i) begin
      if (mem_data_is_instr_i == (m_own == O_IC)) begin
        exp_rsp.push_back({2'(m_own), mem_data_i});
        m_own  <= O_NONE;
        m_resp <= 1'b1;
      end else begin
        m_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: samples 1 ns after each rising edge.
  // --------------------------------------------------------------------------
  bit   prev_strobe = 1'b0;
  req_t got_req;
  rsp_t got_rsp;
  logic [2:0] pulses;
  logic [2:0] exp_pulses;

  always @(posedge clk_i) begin
    #1;
    chk("busy", busy_o, (m_own != O_NONE) || m_resp);
    chk("err", err_o, m_err);
    chk("mem_rd_req", mem_rd_req_o, (m_own == O_IC) || (m_own == O_DR));
    chk("mem_wr_req", mem_wr_req_o, m_own == O_DW);

    if ((mem_rd_req_o || mem_wr_req_o) && !prev_strobe) begin
      if (exp_req.size() == 0) begin
        fail_now("unexpected_mem_request");
      end else begin
        got_req = exp_req.pop_front();
        chk("req_is_instr", mem_req_is_instr_o, got_req.instr);
        chk("req_addr", mem_addr_o, got_req.addr);
        chk("req_size", mem_size_o, got_req.size);
        if (got_req.wr) chk("req_wr_data", mem_wr_data_o, got_req.wdata);
      end
    end
    prev_strobe = mem_rd_req_o || mem_wr_req_o;

    pulses = {ic_rsp_valid_o, dc_rsp_valid_o, dc_wr_done_o};
    if (m_resp) begin
      if (exp_rsp.size() == 0) begin
        fail_now("resp_slot_without_prediction");
      end else begin
        got_rsp = exp_rsp.pop_front();
        exp_pulses = (got_rsp.kind == 2'(O_IC)) ? 3'b100 :
                     (got_rsp.kind == 2'(O_DR)) ? 3'b010 : 3'b001;
        chk("rsp_pulses", pulses, exp_pulses);
        if (got_rsp.kind == 2'(O_IC)) chk("ic_rsp_data", ic_rsp_data_o, got_rsp.data);
        if (got_rsp.kind == 2'(O_DR)) chk("dc_rsp_data", dc_rsp_data_o, got_rsp.data);
      end
    end else begin
      chk("no_rsp_pulse", pulses, 3'b000);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus processes
  // --------------------------------------------------------------------------
  bit run = 1'b0;

  // icache requester: holds its level until it sees its response pulse.
  int ic_wait = 0;
  int ic_cool = 0;
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        ic_rd_req_i = 1'b0;
        ic_cool     = 4;
      end else if (ic_rd_req_i) begin
        if (ic_rsp_valid_o) begin
          ic_rd_req_i = 1'b0;
        end else begin
          ic_wait++;
          if (ic_wait > 400) begin
            fail_now("ic_response_timeout");
            ic_rd_req_i = 1'b0;
          end
        end
      end else if (ic_cool > 0) begin
        ic_cool--;
      end else if (run && $urandom_range(0, 2) == 0) begin
        ic_rd_req_i = 1'b1;
        ic_addr_i   = $urandom & ~32'hF;
        ic_wait     = 0;
      end
    end
  end

  // dcache requester: read, write, or both at once (write goes first).
  int dc_wait = 0;
  int dc_cool = 0;
  int dc_mode = 0;
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        dc_rd_req_i = 1'b0;
        dc_wr_req_i = 1'b0;
        dc_cool     = 4;
      end else if (dc_rd_req_i || dc_wr_req_i) begin
        if (dc_wr_done_o) dc_wr_req_i = 1'b0;
        if (dc_rsp_valid_o) dc_rd_req_i = 1'b0;
        dc_wait++;
        if (dc_wait > 400) begin
          fail_now("dc_response_timeout");
          dc_rd_req_i = 1'b0;
          dc_wr_req_i = 1'b0;
        end
      end else if (dc_cool > 0) begin
        dc_cool--;
      end else if (run && $urandom_range(0, 2) == 0) begin
        dc_mode      = $urandom_range(0, 2);
        dc_rd_req_i  = (dc_mode != 1);
        dc_wr_req_i  = (dc_mode != 0);
        dc_addr_i    = $urandom & ~32'hF;
        dc_wr_data_i = {$urandom, $urandom, $urandom, $urandom};
        dc_size_i    = SW'($urandom_range(0, 3));
        dc_wait      = 0;
      end
    end
  end

  // Memory responder: random latency, occasional wrong-tag read data while a
  // read waits, occasional stray completions while nothing is outstanding,
  // and one late response after a reset that interrupted a transaction.
  bit mem_seen = 1'b0;
  bit mem_late = 1'b0;
  int mem_cnt  = 0;
  initial begin
    forever begin
      @(negedge clk_i);
      mem_data_valid_i    = 1'b0;
      mem_wr_done_i       = 1'b0;
      mem_data_is_instr_i = 1'b0;
      if (rst_i) begin
        if (mem_seen) mem_late = 1'b1;
        mem_seen = 1'b0;
      end else if (mem_late) begin
        mem_data_valid_i    = 1'b1;
        mem_data_is_instr_i = 1'b1;
        mem_data_i          = {$urandom, $urandom, $urandom, $urandom};
        mem_late            = 1'b0;
      end else begin
        if (!mem_seen && (mem_rd_req_o || mem_wr_req_o)) begin
          mem_seen = 1'b1;
          mem_cnt  = $urandom_range(0, 4);
        end
        if (mem_seen) begin
          if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_rd_req_o && $urandom_range(0, 4) == 0) begin
              mem_data_valid_i    = 1'b1;
              mem_data_is_instr_i = ~mem_req_is_instr_o;
              mem_data_i          = {$urandom, $urandom, $urandom, $urandom};
            end
          end else begin
            if (mem_wr_req_o) begin
              mem_wr_done_i = 1'b1;
            end else begin
              mem_data_valid_i    = 1'b1;
              mem_data_is_instr_i = mem_req_is_instr_o;
              mem_data_i          = {$urandom, $urandom, $urandom, $urandom};
            end
            mem_seen = 1'b0;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          if ($urandom_range(0, 1) == 0) begin
            mem_data_valid_i    = 1'b1;
            mem_data_is_instr_i = 1'($urandom_range(0, 1));
            mem_data_i          = {$urandom, $urandom, $urandom, $urandom};
          end else begin
            mem_wr_done_i = 1'b1;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  bit found = 1'b0;
  initial begin
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk_all_zero("reset");
    rst_i = 1'b0;
    run   = 1'b1;

    repeat (2000) @(negedge clk_i);

    // Reset while an icache read is outstanding.
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk_i);
      if (mem_rd_req_o && mem_req_is_instr_o) found = 1'b1;
    end
    if (!found) begin
      fail_now("abort_setup_timeout");
    end else begin
      #2 rst_i = 1'b1;
      #1 chk_all_zero("abort");
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
    end

    repeat (1500) @(negedge clk_i);
    run = 1'b0;
    repeat (300) @(negedge clk_i);

    chk("drain_req_queue", exp_req.size(), 0);
    chk("drain_rsp_queue", exp_rsp.size(), 0);
    chk("drain_busy", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
